// File: rtl/btn_pkg.sv
// Shared constants and types for the button debounce bank.
//   - default parameter values for the bank and its channels
//   - per-channel hold FSM state encoding
//   - helpers that size the hold counter
package btn_pkg;

  localparam int unsigned DEF_N_CH          = 4;
  localparam int unsigned DEF_CNTR_WIDTH    = 4;
  localparam int unsigned DEF_IN_ACTIVE_LOW = 0;
  localparam int unsigned DEF_LONG_TICKS    = 200;
  localparam int unsigned DEF_REPEAT_TICKS  = 50;
  localparam int unsigned DEF_REPEAT_EN     = 1;

  // Hold FSM: waiting for a press, pressed, pressed long enough to auto-repeat
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } btn_fsm_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Hold counter must represent both thresholds
  function automatic int unsigned hold_width(input int unsigned long_t,
                                             input int unsigned rep_t);
    return $clog2(max_u(long_t, rep_t) + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_bank_if.sv
// Bus between the debounce bank and its user.
//   CE          : tick enable for all debounce / hold counters
//   BTN_IN      : raw asynchronous button inputs
//   BTN_STATE   : debounced level, 1 = pressed
//   BTN_PRESS   : one-cycle pulse on debounced 0->1
//   BTN_RELEASE : one-cycle pulse on debounced 1->0
//   BTN_LONG    : one-cycle pulse when held for the long-press time
//   BTN_REPEAT  : one-cycle auto-repeat pulse after a long press
//   ANY_PRESS   : OR of BTN_PRESS, same cycle
// master = user side, slave = debounce bank.
interface btn_debounce_bank_if
  import btn_pkg::*;
#(
  parameter int unsigned N_CH = DEF_N_CH
);

  logic            CE;
  logic [N_CH-1:0] BTN_IN;
  logic [N_CH-1:0] BTN_STATE;
  logic [N_CH-1:0] BTN_PRESS;
  logic [N_CH-1:0] BTN_RELEASE;
  logic [N_CH-1:0] BTN_LONG;
  logic [N_CH-1:0] BTN_REPEAT;
  logic            ANY_PRESS;

  modport master (
    output CE, BTN_IN,
    input  BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_LONG, BTN_REPEAT, ANY_PRESS
  );

  modport slave (
    input  CE, BTN_IN,
    output BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_LONG, BTN_REPEAT, ANY_PRESS
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter, and a hold
// FSM producing long-press and auto-repeat pulses.
//   CLK, RST_N  : clock, async active-low reset
//   ce          : tick enable
//   btn_in      : raw button input
//   btn_state   : debounced level
//   btn_press   : pulse on debounced rise
//   btn_release : pulse on debounced fall
//   btn_long    : pulse on HELD -> LONG
//   btn_repeat  : auto-repeat pulse while in LONG
//   press_c     : unregistered press condition (feeds the bank-level OR)
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH    = DEF_CNTR_WIDTH,
  parameter int unsigned IN_ACTIVE_LOW = DEF_IN_ACTIVE_LOW,
  parameter int unsigned LONG_TICKS    = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS  = DEF_REPEAT_TICKS,
  parameter int unsigned REPEAT_EN     = DEF_REPEAT_EN
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic ce,
  input  logic btn_in,
  output logic btn_state,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_repeat,
  output logic press_c
);

  localparam int unsigned HOLD_W = hold_width(LONG_TICKS, REPEAT_TICKS);
  localparam bit          IN_INV = (IN_ACTIVE_LOW != 0);
  localparam bit          REP_ON = (REPEAT_EN != 0);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_HELD = HELD;
  localparam logic [1:0] ST_LONG = LONG;

  logic [1:0]            sync_q;
  logic                  in_s;
  logic [CNTR_WIDTH-1:0] db_cnt_q, db_cnt_nxt;
  logic                  state_q, state_nxt;
  logic                  rise_c, fall_c;
  logic [1:0]            fsm_q, fsm_nxt;
  logic [HOLD_W-1:0]     hold_q, hold_nxt, hold_inc;
  logic                  long_nxt, rep_nxt;

  // Synchroniser; polarity fix-up applied after the second flop
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], btn_in};
  end

  assign in_s = sync_q[1] ^ IN_INV;

  // Debounce: any agreement restarts the count; a full run of CE ticks flips the level
  always_comb begin
    db_cnt_nxt = db_cnt_q;
    state_nxt  = state_q;
    rise_c     = 1'b0;
    fall_c     = 1'b0;
    if (in_s == state_q) begin
      db_cnt_nxt = '0;
    end else if (ce) begin
      if (&db_cnt_q) begin
        state_nxt  = in_s;
        db_cnt_nxt = '0;
        rise_c     = in_s;
        fall_c     = ~in_s;
      end else begin
        db_cnt_nxt = db_cnt_q + CNTR_WIDTH'(1);
      end
    end
  end

  assign press_c = rise_c;

  // Hold FSM next state; a release always takes priority over thresholds
  always_comb begin
    fsm_nxt  = fsm_q;
    hold_nxt = hold_q;
    long_nxt = 1'b0;
    rep_nxt  = 1'b0;
    hold_inc = hold_q + HOLD_W'(1);
    case (fsm_q)
      ST_IDLE: begin
        if (rise_c) begin
          fsm_nxt  = ST_HELD;
          hold_nxt = '0;
        end
      end
      ST_HELD: begin
        if (fall_c) begin
          fsm_nxt  = ST_IDLE;
          hold_nxt = '0;
        end else if (ce) begin
          if (hold_inc == HOLD_W'(LONG_TICKS)) begin
            fsm_nxt  = ST_LONG;
            hold_nxt = '0;
            long_nxt = 1'b1;
          end else begin
            hold_nxt = hold_inc;
          end
        end
      end
      ST_LONG: begin
        if (fall_c) begin
          fsm_nxt  = ST_IDLE;
          hold_nxt = '0;
        end else if (ce) begin
          if (hold_inc == HOLD_W'(REPEAT_TICKS)) begin
            hold_nxt = '0;
            rep_nxt  = REP_ON;
          end else begin
            hold_nxt = hold_inc;
          end
        end
      end
      default: begin
        fsm_nxt  = ST_IDLE;
        hold_nxt = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      db_cnt_q    <= '0;
      state_q     <= 1'b0;
      fsm_q       <= ST_IDLE;
      hold_q      <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      db_cnt_q    <= db_cnt_nxt;
      state_q     <= state_nxt;
      fsm_q       <= fsm_nxt;
      hold_q      <= hold_nxt;
      btn_press   <= rise_c;
      btn_release <= fall_c;
      btn_long    <= long_nxt;
      btn_repeat  <= rep_nxt;
    end
  end

  assign btn_state = state_q;

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of N_CH independent debounced buttons with press/release,
// long-press and auto-repeat pulses, plus a bank-wide ANY_PRESS.
//   CLK, RST_N : clock, async active-low reset
//   bus        : btn_debounce_bank_if slave (CE, BTN_IN in; all status out)
module btn_debounce_bank
  import btn_pkg::*;
#(
  parameter int unsigned N_CH          = DEF_N_CH,
  parameter int unsigned CNTR_WIDTH    = DEF_CNTR_WIDTH,
  parameter int unsigned IN_ACTIVE_LOW = DEF_IN_ACTIVE_LOW,
  parameter int unsigned LONG_TICKS    = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS  = DEF_REPEAT_TICKS,
  parameter int unsigned REPEAT_EN     = DEF_REPEAT_EN
) (
  input logic               CLK,
  input logic               RST_N,
  btn_debounce_bank_if.slave bus
);

  logic [N_CH-1:0] press_c;

  // One channel per button
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .CNTR_WIDTH    (CNTR_WIDTH),
      .IN_ACTIVE_LOW (IN_ACTIVE_LOW),
      .LONG_TICKS    (LONG_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS),
      .REPEAT_EN     (REPEAT_EN)
    ) u_ch (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .ce          (bus.CE),
      .btn_in      (bus.BTN_IN[i]),
      .btn_state   (bus.BTN_STATE[i]),
      .btn_press   (bus.BTN_PRESS[i]),
      .btn_release (bus.BTN_RELEASE[i]),
      .btn_long    (bus.BTN_LONG[i]),
      .btn_repeat  (bus.BTN_REPEAT[i]),
      .press_c     (press_c[i])
    );
  end

  // Registered from the same conditions as BTN_PRESS so both rise together
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) bus.ANY_PRESS <= 1'b0;
    else        bus.ANY_PRESS <= |press_c;
  end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Directed bench for btn_debounce_bank (N_CH=4, CNTR_WIDTH=4, LONG=20, REPEAT=5).
module tb_btn_debounce_bank;

  localparam int unsigned N_CH = 4;

  logic CLK = 1'b0;
  logic RST_N;

  btn_debounce_bank_if #(.N_CH(N_CH)) bus ();

  btn_debounce_bank #(
    .N_CH          (N_CH),
    .CNTR_WIDTH    (4),
    .IN_ACTIVE_LOW (0),
    .LONG_TICKS    (20),
    .REPEAT_TICKS  (5),
    .REPEAT_EN     (1)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] sel(input bit c, input logic [31:0] v);
    return c ? v : 32'h0;
  endfunction

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_state"},   32'(bus.BTN_STATE),   32'h0);
    check_vec({tag, "_press"},   32'(bus.BTN_PRESS),   32'h0);
    check_vec({tag, "_release"}, 32'(bus.BTN_RELEASE), 32'h0);
    check_vec({tag, "_long"},    32'(bus.BTN_LONG),    32'h0);
    check_vec({tag, "_repeat"},  32'(bus.BTN_REPEAT),  32'h0);
    check_vec({tag, "_any"},     32'(bus.ANY_PRESS),   32'h0);
  endtask

  initial begin
    RST_N      = 1'b0;
    bus.CE     = 1'b1;
    bus.BTN_IN = '0;
    tick();
    tick();
    check_all_zero("reset");
    RST_N = 1'b1;
    tick();
    tick();

    // Ch0 press rises on edge 18; release lands on the long threshold edge 38
    bus.BTN_IN[0] = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      check_vec("ch0_state",   32'(bus.BTN_STATE),   sel(e >= 18 && e < 38, 32'h1));
      check_vec("ch0_press",   32'(bus.BTN_PRESS),   sel(e == 18, 32'h1));
      check_vec("ch0_any",     32'(bus.ANY_PRESS),   sel(e == 18, 32'h1));
      check_vec("ch0_release", 32'(bus.BTN_RELEASE), sel(e == 38, 32'h1));
      check_vec("ch0_long",    32'(bus.BTN_LONG),    32'h0);
      if (e == 20) bus.BTN_IN[0] = 1'b0;
    end

    // Ch1 10-cycle glitch is filtered out
    bus.BTN_IN[1] = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      check_vec("glitch_state",   32'(bus.BTN_STATE),   32'h0);
      check_vec("glitch_press",   32'(bus.BTN_PRESS),   32'h0);
      check_vec("glitch_release", 32'(bus.BTN_RELEASE), 32'h0);
      if (e == 10) bus.BTN_IN[1] = 1'b0;
    end

    // Ch2 held: press at 18, long at 38, repeat every 5 until release at 66
    bus.BTN_IN[2] = 1'b1;
    for (int e = 1; e <= 68; e++) begin
      tick();
      check_vec("ch2_state",   32'(bus.BTN_STATE),   sel(e >= 18 && e < 66, 32'h4));
      check_vec("ch2_press",   32'(bus.BTN_PRESS),   sel(e == 18, 32'h4));
      check_vec("ch2_long",    32'(bus.BTN_LONG),    sel(e == 38, 32'h4));
      check_vec("ch2_repeat",  32'(bus.BTN_REPEAT),
                sel(e > 38 && e < 66 && ((e - 38) % 5) == 0, 32'h4));
      check_vec("ch2_release", 32'(bus.BTN_RELEASE), sel(e == 66, 32'h4));
      if (e == 48) bus.BTN_IN[2] = 1'b0;
    end

    // CE 1-in-4: ch0 and ch3 together, debounce stretches to edge 64
    bus.BTN_IN = 4'b1001;
    for (int e = 1; e <= 66; e++) begin
      bus.CE = ((e % 4) == 0);
      tick();
      check_vec("ce4_state", 32'(bus.BTN_STATE), sel(e >= 64, 32'h9));
      check_vec("ce4_press", 32'(bus.BTN_PRESS), sel(e == 64, 32'h9));
      check_vec("ce4_any",   32'(bus.ANY_PRESS), sel(e == 64, 32'h1));
    end

    // CE back to 1: long press on both channels 20 ticks later
    bus.CE = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      check_vec("ce1_long",   32'(bus.BTN_LONG),   sel(k == 20, 32'h9));
      check_vec("ce1_repeat", 32'(bus.BTN_REPEAT), 32'h0);
      check_vec("ce1_state",  32'(bus.BTN_STATE),  32'h9);
    end

    // Reset mid-cycle during LONG clears outputs at once, no release pulse
    #2 RST_N = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    tick();
    check_all_zero("rst_hold");
    RST_N = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      tick();
      check_vec("post_rst_state",   32'(bus.BTN_STATE),   sel(e >= 18, 32'h9));
      check_vec("post_rst_press",   32'(bus.BTN_PRESS),   sel(e == 18, 32'h9));
      check_vec("post_rst_any",     32'(bus.ANY_PRESS),   sel(e == 18, 32'h1));
      check_vec("post_rst_release", 32'(bus.BTN_RELEASE), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
